// File: rtl/debounce_scheduler_if.sv
// debounce_scheduler_if: button bus between pins and the debouncer.
// i_data raw levels in; o_data/o_press/o_release/o_busy/o_active_ch out.
interface debounce_scheduler_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] i_data;
  logic [NUM_CH-1:0] o_data;
  logic [NUM_CH-1:0] o_press;
  logic [NUM_CH-1:0] o_release;
  logic              o_busy;
  logic [CH_W-1:0]   o_active_ch;

  modport master (
    output i_data,
    input  o_data,
    input  o_press,
    input  o_release,
    input  o_busy,
    input  o_active_ch
  );

  modport slave (
    input  i_data,
    output o_data,
    output o_press,
    output o_release,
    output o_busy,
    output o_active_ch
  );
endinterface

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: NUM_CH button debouncer sharing one round-robin timer.
// Ports: i_Clk, i_Rst (async high), bus (slave: i_data in, filtered/events out).
module debounce_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int c_COUNT_LIMIT = 250000,
  parameter int CNT_W         = 18
) (
  input logic                  i_Clk,
  input logic                  i_Rst,
  debounce_scheduler_if.slave  bus
);
  localparam int CH_W = $clog2(NUM_CH);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_TIMING = 1'b1;

  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [NUM_CH-1:0] r_data;
  logic [NUM_CH-1:0] r_press;
  logic [NUM_CH-1:0] r_release;
  logic [CH_W-1:0]   r_active;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [0:0]        r_state;

  logic [NUM_CH-1:0] w_pend;
  logic              w_found;
  logic [CH_W-1:0]   w_grant;
  logic [CH_W-1:0]   w_idx;
  logic [CH_W-1:0]   w_next;
  logic              w_last;

  assign w_pend = r_sync2 ^ r_data;
  assign w_last = (r_cnt == CNT_W'(c_COUNT_LIMIT - 1));
  assign w_next = (r_active == CH_W'(NUM_CH - 1)) ?
                  '0 : r_active + CH_W'(1);

  // First pending channel at or above rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
      if (!w_found && w_pend[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_data    <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_active  <= '0;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_state   <= S_IDLE;
    end else begin
      r_sync1   <= bus.i_data;
      r_sync2   <= r_sync1;
      r_press   <= '0;
      r_release <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_active <= w_grant;
            r_cnt    <= '0;
            r_state  <= S_TIMING;
          end
        end
        S_TIMING: begin
          if (w_pend[r_active]) begin
            if (w_last) begin
              r_data[r_active] <= r_sync2[r_active];
              if (r_sync2[r_active])
                r_press[r_active] <= 1'b1;
              else
                r_release[r_active] <= 1'b1;
              r_rr_ptr <= w_next;
              r_cnt    <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            // Bounced back to the filtered level: drop it quietly.
            r_rr_ptr <= w_next;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_data      = r_data;
  assign bus.o_press     = r_press;
  assign bus.o_release   = r_release;
  assign bus.o_busy      = (r_state == S_TIMING);
  assign bus.o_active_ch = r_active;
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed checks of the shared-timer debouncer.
// NUM_CH=4, limit 8; latencies counted in edges from the input drive.
module tb_debounce_scheduler;
  localparam int LIM = 8;
  // Drive just after an edge; the next edge is E0, commit at E(2+LIM),
  // observed LIM+3 ticks after the drive.
  localparam int LAT = LIM + 3;
  localparam int GAP = LIM + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  debounce_scheduler_if #(.NUM_CH(4)) bus ();

  debounce_scheduler #(
    .NUM_CH(4),
    .c_COUNT_LIMIT(LIM),
    .CNT_W(4)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_cyc = 0;
  int press_n  = 0;
  int rel_n    = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] d);
    bus.i_data = d;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_data(input int ch, input logic lvl,
                           output int n);
    n = 0;
    while (bus.o_data[ch] !== lvl && n < 60) begin
      tick();
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_busy) busy_cyc++;
      press_n += $countones(bus.o_press);
      rel_n   += $countones(bus.o_release);
      if ((bus.o_press | bus.o_release) != 4'b0)
        check("one_pulse",
              $countones(bus.o_press | bus.o_release), 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int p;
    int r;

    // Reset with all inputs high
    bus.i_data = 4'b1111;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_data", bus.o_data, 0);
    check("rst_press", bus.o_press, 0);
    check("rst_rel", bus.o_release, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_act", bus.o_active_ch, 0);
    rst = 1'b0;
    wait_data(0, 1'b1, n);
    check("rst_ch0_lat", n, LAT);
    check("rst_ch0_press", bus.o_press, 4'b0001);
    wait_data(1, 1'b1, n);
    check("rst_ch1_lat", n, GAP);
    wait_data(2, 1'b1, n);
    check("rst_ch2_lat", n, GAP);
    wait_data(3, 1'b1, n);
    check("rst_ch3_lat", n, GAP);
    check("rst_ch3_press", bus.o_press, 4'b1000);

    // Clean press then release on ch0
    do_reset(4'b0000);
    busy_cyc = 0;
    p = press_n;
    bus.i_data = 4'b0001;
    wait_data(0, 1'b1, n);
    check("press_lat", n, LAT);
    check("press_pulse", bus.o_press, 4'b0001);
    check("press_norel", bus.o_release, 0);
    check("press_busy0", bus.o_busy, 0);
    tick();
    check("press_width", bus.o_press, 0);
    check("press_busycyc", busy_cyc, LIM);
    check("press_count", press_n - p, 1);
    busy_cyc = 0;
    bus.i_data = 4'b0000;
    wait_data(0, 1'b0, n);
    check("rel_lat", n, LAT);
    check("rel_pulse", bus.o_release, 4'b0001);
    tick();
    check("rel_width", bus.o_release, 0);
    check("rel_busycyc", busy_cyc, LIM);

    // Bounce on ch1
    p = press_n;
    r = rel_n;
    bus.i_data = 4'b0010;
    repeat (5) tick();
    check("bnc_busy1", bus.o_busy, 1);
    check("bnc_act", bus.o_active_ch, 1);
    bus.i_data = 4'b0000;
    repeat (6) tick();
    check("bnc_data", bus.o_data, 0);
    check("bnc_busy0", bus.o_busy, 0);
    check("bnc_press", press_n - p, 0);
    check("bnc_rel", rel_n - r, 0);
    check("bnc_rr", dut.r_rr_ptr, 2);

    // Simultaneous requests on ch0, ch2, ch3
    do_reset(4'b0000);
    bus.i_data = 4'b1101;
    wait_data(0, 1'b1, n);
    check("sim_ch0_lat", n, LAT);
    check("sim_ch0_only", bus.o_data, 4'b0001);
    wait_data(2, 1'b1, n);
    check("sim_ch2_lat", n, GAP);
    wait_data(3, 1'b1, n);
    check("sim_ch3_lat", n, GAP);
    check("sim_data", bus.o_data, 4'b1101);

    // Round-robin: after ch1, ch3 wins over ch0
    do_reset(4'b0000);
    bus.i_data = 4'b0010;
    wait_data(1, 1'b1, n);
    check("rr_ch1_lat", n, LAT);
    check("rr_ptr2", dut.r_rr_ptr, 2);
    bus.i_data = 4'b1011;
    wait_data(3, 1'b1, n);
    check("rr_ch3_lat", n, LAT);
    check("rr_ch0_wait", bus.o_data[0], 0);
    wait_data(0, 1'b1, n);
    check("rr_ch0_lat", n, GAP);

    // Async reset mid-TIMING on ch2
    do_reset(4'b0000);
    bus.i_data = 4'b0100;
    repeat (8) tick();
    check("ar_cnt", dut.r_cnt, 5);
    check("ar_busy1", bus.o_busy, 1);
    check("ar_act2", bus.o_active_ch, 2);
    p = press_n;
    rst = 1'b1;
    #1;
    check("ar_data", bus.o_data, 0);
    check("ar_busy0", bus.o_busy, 0);
    check("ar_act0", bus.o_active_ch, 0);
    check("ar_press", bus.o_press, 0);
    #2;
    rst = 1'b0;
    check("ar_nopulse", press_n - p, 0);
    wait_data(2, 1'b1, n);
    check("ar_ch2_lat", n, LAT);
    tick();
    check("ar_press_n", press_n - p, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
